// File: rtl/digtal_pkg.sv
// Shared types and constants for the dual-channel buffer arbiter.
// Read FSM states, default sync word and fill byte.
package digtal_pkg;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_HEAD,
    RD_PAY,
    RD_PWAIT
  } rd_state_e;

  localparam logic [63:0] SYNC_WORD = 64'hEB9090EBEB9090EB;
  localparam logic [7:0]  FILL_DEF  = 8'h55;

  function automatic logic [7:0] hdr_byte(
    input logic [63:0] w,
    input logic [2:0]  idx
  );
    logic [63:0] s;
    s = w << {idx, 3'b000};
    return s[63:56];
  endfunction

endpackage

// File: rtl/digtal_wr_arbiter.sv
// Two 1-entry holding registers, round-robin RAM write grant, write pointer.
// DIGTAL_OVF_COUNT_EN adds a saturating dropped-byte counter.
module digtal_wr_arbiter
  import digtal_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rd_a_i,
  input  logic [7:0]        data_a_i,
  input  logic              rd_b_i,
  input  logic [7:0]        data_b_i,
  input  logic              full_i,
  output logic              wr_en_o,
  output logic [7:0]        wr_data_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic              overflow_o
`ifdef DIGTAL_OVF_COUNT_EN
  ,
  output logic [15:0]       ovf_count_o
`endif
);

  logic              va_q, va_d;
  logic              vb_q, vb_d;
  logic [7:0]        da_q, da_d;
  logic [7:0]        db_q, db_d;
  logic              prio_b_q, prio_b_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic              ovf_q, ovf_d;
  logic              gnt_a, gnt_b;
  logic              drop_a, drop_b;

  always_comb begin
    gnt_a    = ~full_i & va_q & (~vb_q | ~prio_b_q);
    gnt_b    = ~full_i & vb_q & (~va_q | prio_b_q);
    // a register being written this cycle can take a new byte
    drop_a   = rd_a_i & va_q & ~gnt_a;
    drop_b   = rd_b_i & vb_q & ~gnt_b;
    va_d     = va_q & ~gnt_a;
    vb_d     = vb_q & ~gnt_b;
    da_d     = da_q;
    db_d     = db_q;
    if (rd_a_i && !drop_a) begin
      va_d = 1'b1;
      da_d = data_a_i;
    end
    if (rd_b_i && !drop_b) begin
      vb_d = 1'b1;
      db_d = data_b_i;
    end
    prio_b_d = prio_b_q;
    if (va_q && vb_q && !full_i) prio_b_d = ~prio_b_q;
    wptr_d   = wptr_q + ADDR_W'(gnt_a | gnt_b);
    ovf_d    = ovf_q | drop_a | drop_b;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      va_q     <= 1'b0;
      vb_q     <= 1'b0;
      da_q     <= '0;
      db_q     <= '0;
      prio_b_q <= 1'b0;
      wptr_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      va_q     <= va_d;
      vb_q     <= vb_d;
      da_q     <= da_d;
      db_q     <= db_d;
      prio_b_q <= prio_b_d;
      wptr_q   <= wptr_d;
      ovf_q    <= ovf_d;
    end
  end

  assign wr_en_o    = gnt_a | gnt_b;
  assign wr_data_o  = gnt_b ? db_q : da_q;
  assign wr_addr_o  = wptr_q;
  assign overflow_o = ovf_q;

`ifdef DIGTAL_OVF_COUNT_EN
  logic [15:0] cnt_q, cnt_d;
  logic [16:0] sum;

  always_comb begin
    sum   = {1'b0, cnt_q} + {16'd0, drop_a} + {16'd0, drop_b};
    cnt_d = sum[16] ? 16'hFFFF : sum[15:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign ovf_count_o = cnt_q;
`endif

endmodule

// File: rtl/digtal_buffer_arbiter.sv
// Ring buffer shared by two byte streams with CS-triggered framed readout.
// DIGTAL_OVF_COUNT_EN adds the Ovf_Count output.
module digtal_buffer_arbiter
  import digtal_pkg::*;
#(
  parameter int          ADDR_W    = 12,
  parameter int          FRAME_LEN = 64,
  parameter int          INS_LEN   = 4,
  parameter logic [63:0] INS_WORD  = SYNC_WORD,
  parameter logic [7:0]  FILL_BYTE = FILL_DEF
) (
  input  logic              Clock_29491200Hz,
  input  logic              Reset,
  input  logic              RD_A,
  input  logic              RD_B,
  input  logic [7:0]        Rx_Data_A,
  input  logic [7:0]        Rx_Data_B,
  input  logic              CS,
  output logic [7:0]        RAM_Data_In,
  output logic [ADDR_W-1:0] RAM_WRADD,
  output logic [ADDR_W-1:0] RAM_RDADD,
  output logic              RAM_WREN,
  output logic              RAM_RDEN,
  input  logic [7:0]        RAM_Q,
  output logic [7:0]        Out_Data,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic              Frame_Active,
  output logic [ADDR_W:0]   Fill_Level,
  output logic              Overflow
`ifdef DIGTAL_OVF_COUNT_EN
  ,
  output logic [15:0]       Ovf_Count
`endif
);

  localparam int            CW       = ADDR_W + 1;
  localparam int            DEPTH    = 1 << ADDR_W;
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
  localparam logic [CW-1:0] FLEN     = CW'(FRAME_LEN);
  localparam logic [2:0]    HLAST    = 3'(INS_LEN - 1);

  rd_state_e         state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     fill_q, fill_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [7:0]        od_q, od_d;
  logic              ov_q, ov_d;
  logic              cs_q, cs_prev_q;
  logic              cs_rise, free, rd_issue, wr_en;

  digtal_wr_arbiter #(.ADDR_W(ADDR_W)) u_wr (
    .clk_i      (Clock_29491200Hz),
    .rst_i      (Reset),
    .rd_a_i     (RD_A),
    .data_a_i   (Rx_Data_A),
    .rd_b_i     (RD_B),
    .data_b_i   (Rx_Data_B),
    .full_i     (fill_q == FULL_LVL),
    .wr_en_o    (wr_en),
    .wr_data_o  (RAM_Data_In),
    .wr_addr_o  (RAM_WRADD),
    .overflow_o (Overflow)
`ifdef DIGTAL_OVF_COUNT_EN
    ,
    .ovf_count_o(Ovf_Count)
`endif
  );

  always_comb begin
    cs_rise  = cs_q & ~cs_prev_q;
    free     = ~ov_q | Out_Ready;
    rd_issue = 1'b0;
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    od_d     = od_q;
    ov_d     = ov_q & ~Out_Ready;
    unique case (state_q)
      RD_IDLE: begin
        if (cs_rise) begin
          state_d = RD_HEAD;
          idx_d   = '0;
        end
      end
      RD_HEAD: begin
        if (free) begin
          od_d  = hdr_byte(INS_WORD, idx_q);
          ov_d  = 1'b1;
          idx_d = idx_q + 3'd1;
          if (idx_q == HLAST) begin
            state_d = RD_PAY;
            cnt_d   = '0;
          end
        end
      end
      RD_PAY: begin
        if (cnt_q == FLEN) begin
          if (free) state_d = RD_IDLE;
        end else if (free) begin
          if (fill_q != '0) begin
            rd_issue = 1'b1;
            state_d  = RD_PWAIT;
          end else begin
            od_d  = FILL_BYTE;
            ov_d  = 1'b1;
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      RD_PWAIT: begin
        od_d    = RAM_Q;
        ov_d    = 1'b1;
        cnt_d   = cnt_q + CW'(1);
        state_d = RD_PAY;
      end
      default: state_d = RD_IDLE;
    endcase
    rptr_d = rptr_q + ADDR_W'(rd_issue);
    fill_d = fill_q + CW'(wr_en) - CW'(rd_issue);
  end

  always_ff @(posedge Clock_29491200Hz) begin
    if (Reset) begin
      state_q   <= RD_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      fill_q    <= '0;
      rptr_q    <= '0;
      od_q      <= '0;
      ov_q      <= 1'b0;
      cs_q      <= 1'b0;
      cs_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      fill_q    <= fill_d;
      rptr_q    <= rptr_d;
      od_q      <= od_d;
      ov_q      <= ov_d;
      cs_q      <= CS;
      cs_prev_q <= cs_q;
    end
  end

  assign RAM_WREN     = wr_en;
  assign RAM_RDEN     = rd_issue;
  assign RAM_RDADD    = rptr_q;
  assign Out_Data     = od_q;
  assign Out_Valid    = ov_q;
  assign Frame_Active = (state_q != RD_IDLE);
  assign Fill_Level   = fill_q;

endmodule
